// File: rtl/burst_ram_responder.sv
// Purpose: block-RAM backed responder for single-command br_ read/write bursts of BURST_COUNT beats.
// Latency: first read beat appears CYCLES_BEFORE_DATA_VALID cycles after accept; write beats are taken on consecutive edges.
// Backpressure: busy blocks new commands; cmd_en while busy is dropped, and beats have no flow control.
module burst_ram_responder #(
    parameter DATA_FILE                = "",
    parameter int DATA_BITWIDTH        = 64,
    parameter int DEPTH_BITWIDTH       = 8,
    parameter int BURST_COUNT          = 4,
    parameter int CYCLES_BEFORE_INITIATED  = 10,
    parameter int CYCLES_BEFORE_DATA_VALID = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd,
    input  logic                         cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]    addr,
    input  logic [DATA_BITWIDTH-1:0]     wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   data_mask,
    output logic [DATA_BITWIDTH-1:0]     rd_data,
    output logic                         rd_data_valid,
    output logic                         busy
);

    localparam int NBYTES = DATA_BITWIDTH / 8;
    localparam int DEPTH  = 1 << DEPTH_BITWIDTH;
    localparam int INIT_W = $clog2(CYCLES_BEFORE_INITIATED + 1);
    localparam int WAIT_W = $clog2(CYCLES_BEFORE_DATA_VALID + 1);
    localparam int BEAT_W = $clog2(BURST_COUNT + 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_WR_BURST
    } state_t;

    state_t                      state_q;
    logic                        busy_q;
    logic                        rd_valid_q;
    logic [DATA_BITWIDTH-1:0]    rd_data_q;
    logic [INIT_W-1:0]           init_cnt_q;
    logic [WAIT_W-1:0]           wait_cnt_q;
    logic [BEAT_W-1:0]           beat_q;
    logic [DEPTH_BITWIDTH-1:0]   addr_q;

    logic [DATA_BITWIDTH-1:0]    mem_q [0:DEPTH-1];

    logic                        wr_en;
    logic [DEPTH_BITWIDTH-1:0]   wr_addr;
    logic [DEPTH_BITWIDTH-1:0]   rd_addr;

    // Beat addresses wrap modulo the memory size; beat 0 of a write uses the live address.
    always_comb begin
        rd_addr = addr_q + DEPTH_BITWIDTH'(beat_q);
        wr_en   = 1'b0;
        wr_addr = addr_q + DEPTH_BITWIDTH'(beat_q);
        if (state_q == ST_IDLE && cmd_en && cmd) begin
            wr_en   = 1'b1;
            wr_addr = addr;
        end else if (state_q == ST_WR_BURST) begin
            wr_en   = 1'b1;
        end
    end

    // Byte-masked write port; reset forces INIT so nothing is written while rst_n is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (!data_mask[b]) begin
                    mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Control FSM with registered busy / read-valid / read-data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            beat_q     <= '0;
            addr_q     <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == INIT_W'(CYCLES_BEFORE_INITIATED - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cmd_en) begin
                        addr_q <= addr;
                        if (!cmd) begin
                            state_q    <= ST_RD_WAIT;
                            busy_q     <= 1'b1;
                            wait_cnt_q <= '0;
                            beat_q     <= '0;
                        end else if (BURST_COUNT > 1) begin
                            // Beat 0 is written this edge; the rest follow back to back.
                            state_q <= ST_WR_BURST;
                            busy_q  <= 1'b1;
                            beat_q  <= BEAT_W'(1);
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_cnt_q == WAIT_W'(CYCLES_BEFORE_DATA_VALID - 1)) begin
                        rd_data_q  <= mem_q[rd_addr];
                        rd_valid_q <= 1'b1;
                        beat_q     <= BEAT_W'(1);
                        state_q    <= ST_RD_BURST;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_RD_BURST: begin
                    if (beat_q == BEAT_W'(BURST_COUNT)) begin
                        // rd_data keeps the last beat; only valid drops.
                        rd_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        rd_data_q <= mem_q[rd_addr];
                        beat_q    <= beat_q + 1'b1;
                    end
                end
                ST_WR_BURST: begin
                    // busy drops with the final beat so the next command can land right after it.
                    if (beat_q == BEAT_W'(BURST_COUNT - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign busy          = busy_q;

endmodule
